multdiv_seq: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath. It computes the products and quotients consumed by the hi/lo register pair.
- Multiply uses 1-bit/cycle shift-add; divide uses 1-bit/cycle restoring division.
- The block sits between execute-stage operands and the hi/lo register.
- Its write-enable output drives the hi/lo register write port directly.
- Its busy output stalls the pipeline while an operation is in flight.

---
 rtl/multdiv_seq.sv | 146 ++++++++++++++
 tb/tb_multdiv_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Iterative multiply/divide unit feeding the hi/lo register pair.
// Multiply: 1-bit/cycle shift-add. Divide: 1-bit/cycle restoring division.
// Optional signed support is compiled in with `define MDU_SIGNED_EN; without it
// is_signed is ignored and every operation is unsigned. Latency is the same.
module multdiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             multordiv,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic              mul_q;
  logic              neg_q;    // product / quotient must be negated
  logic              neg_r_q;  // remainder must be negated
  logic [WIDTH-1:0]  m_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  r_hi_q;   // partial product high / partial remainder
  logic [WIDTH-1:0]  r_lo_q;   // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0]  hi_q, lo_q;

  logic              capture, last;
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;

`ifdef MDU_SIGNED_EN
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign capture = start && (state_q != StRun);
  assign last    = (state_q == StRun) && !flush && (cnt_q == CntW'(WIDTH - 1));

  // One iteration of the selected algorithm from the current working registers.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    addend   = r_lo_q[0] ? m_q : '0;
    mul_sum  = {1'b0, r_hi_q} + {1'b0, addend};
    div_sh   = {r_hi_q, r_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    div_ok   = !div_diff[WIDTH];
    if (mul_q) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], r_lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {r_lo_q[WIDTH-2:0], div_ok};
    end
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    if (mul_q) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else begin
      res_hi = neg_r_q ? -step_hi : step_hi;
      res_lo = neg_q ? -step_lo : step_lo;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; flush wins over completion on the final edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (flush)     state_d = StIdle;
        else if (last) state_d = StDone;
      end
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, iteration, and result load on the RUN-to-DONE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      m_q     <= '0;
      r_hi_q  <= '0;
      r_lo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (capture) begin
      cnt_q   <= '0;
      mul_q   <= multordiv;
      neg_q   <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      m_q     <= multordiv ? a_mag : b_mag;
      r_hi_q  <= '0;
      r_lo_q  <= multordiv ? b_mag : a_mag;
    end else if (state_q == StRun) begin
      cnt_q  <= cnt_q + CntW'(1);
      r_hi_q <= step_hi;
      r_lo_q <= step_lo;
      if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign we   = done;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq (WIDTH = 32).
module tb_multdiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, multordiv, is_signed, flush;
  logic [W-1:0] a, b;
  logic         busy, done, we;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  multdiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .multordiv (multordiv),
    .is_signed (is_signed),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .we        (we),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle N: drive operands with start; returns in cycle N+1 with start low and
  // operands scrambled to zero so late changes are shown to have no effect.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic mul,
                       input logic sgn, input string tag);
    chk({tag, "_idle_before"}, 64'(busy), 64'd0);
    a = av; b = bv; multordiv = mul; is_signed = sgn; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0; multordiv = ~mul; is_signed = 1'b0;
  endtask

  // Full operation with latency checks: busy N+1..N+32, done/we at N+33 only.
  task automatic run_check(input logic [W-1:0] av, input logic [W-1:0] bv, input logic mul,
                           input logic sgn, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input string tag);
    issue(av, bv, mul, sgn, tag);
    for (int k = 1; k <= W; k++) begin
      chk({tag, "_run"}, 64'({busy, done, we}), 64'(3'b100));
      tick();
    end
    chk({tag, "_done"}, 64'({busy, done, we}), 64'(3'b011));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    tick();
    chk({tag, "_after"}, 64'({busy, done, we}), 64'(3'b000));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; multordiv = 1'b0; is_signed = 1'b0; flush = 1'b0;
    a = '0; b = '0;
    tick();
    tick();
    chk("reset_ctrl", 64'({busy, done, we}), 64'(3'b000));
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick();

    run_check(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "mul_max");
    run_check(32'd100, 32'd7, 1'b0, 1'b0, 32'd2, 32'd14, "div_100_7");
    run_check(32'd5, 32'd0, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFF, "div_by_zero");

    // start pulsed at N+10 while busy is ignored; single done at N+33.
    issue(32'd3, 32'd4, 1'b1, 1'b0, "busy_start");
    for (int k = 1; k <= W; k++) begin
      chk("busy_start_run", 64'({busy, done}), 64'(2'b10));
      if (k == 10) begin
        start = 1'b1; a = 32'd9; b = 32'd9; multordiv = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("busy_start_done", 64'({done, we}), 64'(2'b11));
    chk("busy_start_lo", {hi, lo}, 64'd12);
    tick();
    chk("busy_start_single", 64'({busy, done}), 64'(2'b00));

    // start held through DONE: back-to-back second operation, done at N+66.
    a = 32'd7; b = 32'd6; multordiv = 1'b1; start = 1'b1;
    tick();
    a = 32'd5; b = 32'd5;
    for (int k = 1; k <= W; k++) begin
      chk("b2b_run1", 64'({busy, done}), 64'(2'b10));
      tick();
    end
    chk("b2b_done1", 64'({done, we}), 64'(2'b11));
    chk("b2b_res1", {hi, lo}, 64'd42);
    tick();
    start = 1'b0; a = '0; b = '0;
    for (int k = W + 2; k <= 2 * W + 1; k++) begin
      chk("b2b_run2", 64'({busy, done}), 64'(2'b10));
      tick();
    end
    chk("b2b_done2", 64'({done, we}), 64'(2'b11));
    chk("b2b_res2", {hi, lo}, 64'd25);
    tick();
    chk("b2b_after", 64'({busy, done}), 64'(2'b00));

    // flush at N+12: busy low at N+13, no done, hi/lo hold 0/25.
    issue(32'd100, 32'd7, 1'b0, 1'b0, "flush");
    for (int k = 1; k <= 12; k++) begin
      chk("flush_run", 64'(busy), 64'd1);
      if (k == 12) flush = 1'b1;
      tick();
    end
    flush = 1'b0;
    chk("flush_busy_drop", 64'(busy), 64'd0);
    for (int k = 0; k < 30; k++) begin
      chk("flush_no_done", 64'({busy, done, we}), 64'(3'b000));
      tick();
    end
    chk("flush_hilo_kept", {hi, lo}, 64'd25);

`ifdef MDU_SIGNED_EN
    run_check(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "smul_m3_5");
    run_check(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "sdiv_m7_2");
    run_check(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 32'h8000_0000, "sdiv_min_m1");
`else
    // is_signed ignored: 0xFFFFFFFD * 5 = 0x4_FFFFFFF1, 0xFFFFFFF9 / 2 = 0x7FFFFFFC r 1.
    run_check(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFF1, "umul_sig_ign");
    run_check(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC, "udiv_sig_ign");
`endif

    // Reset mid-RUN at N+20 clears everything immediately.
    issue(32'd11, 32'd13, 1'b1, 1'b0, "rst_mid");
    for (int k = 1; k < 20; k++) tick();
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_ctrl", 64'({busy, done, we}), 64'(3'b000));
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_check(32'd6, 32'd7, 1'b1, 1'b0, 32'd0, 32'd42, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
